// File: rtl/twiddle_gen.sv
// twiddle_gen: streams FFT twiddle factors W_N^k = exp(-j*2*pi*k/N) for
// k = i*stride mod N, i = 0..N-1, through a two-stage valid/ready pipeline.
// A quarter-wave cosine table is folded into all four quadrants.
// Optional feature: define TWIDDLE_GEN_INVERSE_EN to add the 'inverse' input,
// which conjugates the output (tw_im negated) for an inverse FFT.
module twiddle_gen #(
    parameter int LOG_N = 6,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LOG_N-1:0] stride,
`ifdef TWIDDLE_GEN_INVERSE_EN
    input  logic             inverse,
`endif
    input  logic             tw_ready,
    output logic             tw_valid,
    output logic [WIDTH-1:0] tw_re,
    output logic [WIDTH-1:0] tw_im,
    output logic             tw_bypass,
    output logic             busy,
    output logic             done
);

    localparam int N      = 1 << LOG_N;
    localparam int QN     = N / 4;
    localparam int STAGES = 2;

    typedef logic [QN:0][WIDTH-1:0] rom_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // Quarter-wave table C[m] = round(cos(2*pi*m/N) * 2^(WIDTH-1)), built at
    // elaboration with a Q30 fixed-point Taylor series (x <= pi/2, so 12 terms
    // leave error far below one output LSB). +1.0 saturates to max positive.
    function automatic rom_t build_rom();
        rom_t   rom;
        longint pi_q30;
        longint x, x2, term, acc, v, vmax;
        pi_q30 = 64'sd3373259426;
        vmax   = (longint'(1) << (WIDTH - 1)) - 1;
        for (int m = 0; m <= QN; m++) begin
            x    = (longint'(m) * pi_q30 * 2) >>> LOG_N;
            x2   = (x * x) >>> 30;
            term = longint'(1) << 30;
            acc  = term;
            for (int n = 1; n <= 12; n++) begin
                term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
                acc  = acc + term;
            end
            v = (acc + (longint'(1) << (30 - WIDTH))) >>> (31 - WIDTH);
            if (v > vmax) v = vmax;
            if (v < 0)    v = 0;
            rom[m] = v[WIDTH-1:0];
        end
        return rom;
    endfunction

    localparam rom_t             ROM    = build_rom();
    localparam logic [LOG_N-2:0] QN_IDX = (LOG_N-1)'(QN);

    state_t           state, state_nx;
    logic [LOG_N-1:0] i_cnt;
    logic [LOG_N-1:0] k_acc;
    logic [LOG_N-1:0] stride_q;
    logic [LOG_N-1:0] k_q;
    logic [STAGES:1]  vld_pipe;
    logic [STAGES:1]  last_pipe;
    logic             inv_q;
    logic             adv;
    logic             issue;
    logic             accept;

    logic [1:0]       quad;
    logic [LOG_N-2:0] idx_a, idx_b;
    logic [WIDTH-1:0] c_a, c_b;
    logic [WIDTH-1:0] re_nx, im_nx;
    logic             byp_nx;

    assign adv      = !vld_pipe[STAGES] | tw_ready;
    assign issue    = (state == RUN) & adv;
    assign accept   = (state == IDLE) & start;
    assign tw_valid = vld_pipe[STAGES];
    assign busy     = (state != IDLE);
    assign done     = vld_pipe[STAGES] & tw_ready & last_pipe[STAGES];

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state: RUN until index N-1 is issued, DRAIN until the last handshake
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)               state_nx = RUN;
            RUN:     if (issue && (&i_cnt))   state_nx = DRAIN;
            DRAIN:   if (done)                state_nx = IDLE;
            default:                          state_nx = IDLE;
        endcase
    end

    // Sequence control: latch configuration on start, step i and k per issue
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i_cnt    <= '0;
            k_acc    <= '0;
            stride_q <= '0;
            inv_q    <= 1'b0;
        end else if (accept) begin
            i_cnt    <= '0;
            k_acc    <= '0;
            stride_q <= stride;
`ifdef TWIDDLE_GEN_INVERSE_EN
            inv_q    <= inverse;
`else
            inv_q    <= 1'b0;
`endif
        end else if (issue) begin
            i_cnt    <= i_cnt + 1'b1;
            k_acc    <= k_acc + stride_q;
        end
    end

    // Quadrant fold of the quarter-wave table; k == 0 is forced to a bypass
    always_comb begin
        quad   = k_q[LOG_N-1:LOG_N-2];
        idx_a  = {1'b0, k_q[LOG_N-3:0]};
        idx_b  = QN_IDX - idx_a;
        c_a    = ROM[idx_a];
        c_b    = ROM[idx_b];
        re_nx  = c_a;
        im_nx  = -c_b;
        byp_nx = (k_q == '0);
        case (quad)
            2'd0: begin re_nx = c_a;  im_nx = -c_b; end
            2'd1: begin re_nx = -c_b; im_nx = -c_a; end
            2'd2: begin re_nx = -c_a; im_nx = c_b;  end
            default: begin re_nx = c_b; im_nx = c_a; end
        endcase
        if (inv_q) im_nx = -im_nx;
        if (byp_nx) begin
            re_nx = '0;
            im_nx = '0;
        end
    end

    // Two-stage pipeline: k register, then folded ROM output; frozen on stall
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            k_q       <= '0;
            tw_re     <= '0;
            tw_im     <= '0;
            tw_bypass <= 1'b0;
        end else if (adv) begin
            vld_pipe[1]  <= (state == RUN);
            last_pipe[1] <= &i_cnt;
            k_q          <= k_acc;
            vld_pipe[2]  <= vld_pipe[1];
            last_pipe[2] <= last_pipe[1];
            tw_re        <= re_nx;
            tw_im        <= im_nx;
            tw_bypass    <= byp_nx;
        end
    end

endmodule

// File: tb/tb_twiddle_gen.sv
// Randomized bench for twiddle_gen: a real-valued exp(-j*2*pi*k/N) model is
// compared against every accepted sample, with random back-pressure, start
// pulses during a run, and a mid-sequence asynchronous reset.
module tb_twiddle_gen;

    localparam int  LOG_N = 6;
    localparam int  WIDTH = 16;
    localparam int  N     = 1 << LOG_N;
    localparam int  MAXV  = (1 << (WIDTH - 1)) - 1;
    localparam real PI    = 3.14159265358979323846;

    logic             clock;
    logic             reset;
    logic             start;
    logic [LOG_N-1:0] stride;
`ifdef TWIDDLE_GEN_INVERSE_EN
    logic             inverse;
`endif
    logic             tw_ready;
    logic             tw_valid;
    logic [WIDTH-1:0] tw_re;
    logic [WIDTH-1:0] tw_im;
    logic             tw_bypass;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    twiddle_gen #(.LOG_N(LOG_N), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stride    (stride),
`ifdef TWIDDLE_GEN_INVERSE_EN
        .inverse   (inverse),
`endif
        .tw_ready  (tw_ready),
        .tw_valid  (tw_valid),
        .tw_re     (tw_re),
        .tw_im     (tw_im),
        .tw_bypass (tw_bypass),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Round half away from zero, then clamp to the symmetric Q(WIDTH-1) range
    function automatic int quant(input real x);
        real y;
        int  v;
        y = x * (2.0 ** (WIDTH - 1));
        v = (y >= 0.0) ? $rtoi(y + 0.5) : -$rtoi(-y + 0.5);
        if (v > MAXV)  v = MAXV;
        if (v < -MAXV) v = -MAXV;
        return v;
    endfunction

    // Reference twiddle exp(-j*2*pi*k/N), conjugated when inv is set
    task automatic model(input int k, input bit inv,
                         output logic [WIDTH-1:0] re, output logic [WIDTH-1:0] im,
                         output logic byp);
        real th;
        int  vr, vi;
        th = 2.0 * PI * real'(k) / real'(N);
        vr = quant($cos(th));
        vi = quant(-$sin(th));
        if (inv) vi = -vi;
        if (k == 0) begin
            vr = 0;
            vi = 0;
        end
        re  = WIDTH'(vr);
        im  = WIDTH'(vi);
        byp = (k == 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"},  tw_valid,  0);
        chk({tag, "_re"},     tw_re,     0);
        chk({tag, "_im"},     tw_im,     0);
        chk({tag, "_bypass"}, tw_bypass, 0);
        chk({tag, "_busy"},   busy,      0);
        chk({tag, "_done"},   done,      0);
    endtask

    // One sequence. Called just after a falling edge; start is raised at once.
    // restart_at: cycle to pulse start again mid-run (0 = never).
    // abort_at:   handshake count at which reset is asserted (0 = never).
    task automatic run_seq(input int sv, input int rdy_pct, input int restart_at,
                           input int abort_at, input bit inv);
        int               cnt, dones, cyc, k;
        logic             pv, pr, byp;
        logic [WIDTH-1:0] re, im;
        cnt   = 0;
        dones = 0;
        cyc   = 0;
        pv    = 1'b0;
        pr    = 1'b1;
        stride = LOG_N'(sv);
`ifdef TWIDDLE_GEN_INVERSE_EN
        inverse = inv;
`endif
        start    = 1'b1;
        tw_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        chk("busy_run", busy, 1);
        while (cnt < N && cyc < 4000) begin
            @(negedge clock);
            cyc++;
            start    = (cyc == restart_at);
            tw_ready = (cyc >= 20 && cyc < 25) ? 1'b0 : ($urandom_range(99) < rdy_pct);
            #1;
            if (cyc == 1) chk("lat_c1_valid", tw_valid, 0);
            if (cyc == 2) chk("lat_c2_valid", tw_valid, 1);
            if (pv && !pr) chk("stall_valid", tw_valid, 1);
            if (tw_valid) begin
                k = (cnt * sv) % N;
                model(k, inv, re, im, byp);
                chk($sformatf("re_k%0d", k), tw_re, re);
                chk($sformatf("im_k%0d", k), tw_im, im);
                chk($sformatf("byp_k%0d", k), tw_bypass, byp);
            end
            if (tw_valid && tw_ready) begin
                chk($sformatf("done_i%0d", cnt), done, (cnt == N - 1));
                if (done) dones++;
                cnt++;
                if (cnt == abort_at) begin
                    reset = 1'b1;
                    #1;
                    chk_quiet("abort");
                    start = 1'b0;
                    @(negedge clock);
                    #1;
                    chk_quiet("abort_hold");
                    reset = 1'b0;
                    return;
                end
            end else begin
                chk("done_idle", done, 0);
            end
            pv = tw_valid;
            pr = tw_ready;
        end
        start = 1'b0;
        if (cnt < N) chk("timeout_count", cnt, N);
        tw_ready = 1'b1;
        repeat (2) begin
            @(negedge clock);
            #1;
            chk("tail_valid", tw_valid, 0);
            chk("tail_busy",  busy,     0);
            chk("tail_done",  done,     0);
        end
        chk("done_pulses", dones, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        stride   = '0;
        tw_ready = 1'b0;
`ifdef TWIDDLE_GEN_INVERSE_EN
        inverse  = 1'b0;
`endif
        repeat (3) @(negedge clock);
        #1;
        chk_quiet("reset");
        reset = 1'b0;
        run_seq(1, 100, 0, 0, 1'b0);
        run_seq(3, 100, 0, 0, 1'b0);
        run_seq(1, 60, 0, 0, 1'b0);
        run_seq(0, 70, 0, 0, 1'b0);
        run_seq(5, 50, 10, 0, 1'b0);
        run_seq(1, 100, 0, 20, 1'b0);
        run_seq(7, 80, 0, 0, 1'b0);
        for (int t = 0; t < 4; t++)
            run_seq($urandom_range(N - 1), $urandom_range(100, 40),
                    $urandom_range(30), 0, 1'b0);
`ifdef TWIDDLE_GEN_INVERSE_EN
        run_seq(8, 100, 0, 0, 1'b1);
        run_seq($urandom_range(N - 1), 60, 0, 0, 1'b1);
        run_seq(1, 100, 0, 0, 1'b0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
